// File: rtl/mpu_matrix_loader_pkg.sv
// Shared definitions for the matrix loader and determinant stage: sizes,
// loader FSM states and the flat-bus element position helper.
package mpu_matrix_loader_pkg;

    localparam int MAX_N  = 5;
    localparam int ELEM_W = 8;
    localparam int DET_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    // LSB of element (row,col) on a row-major bus of n x n elements, w bits each
    function automatic int elem_lsb(input int row, input int col, input int n, input int w);
        return (row * n + col) * w;
    endfunction

endpackage

// File: rtl/mpu_rc_counter.sv
// Row/column position counter for a square matrix of order 'size'; column wraps
// at size-1 and advances the row. 'last' flags the bottom-right element.
module mpu_rc_counter #(
    parameter int MAX_N = 5,
    parameter int CW    = $clog2(MAX_N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic [7:0]    size,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [7:0]    lim;
    logic          col_end;

    assign lim     = size - 8'd1;
    assign col_end = (8'(col_q) == lim);
    assign last    = col_end && (8'(row_q) == lim);
    assign row     = row_q;
    assign col     = col_q;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_q + CW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/mpu_matrix_loader.sv
// Byte-stream matrix loader: a size byte followed by size*size row-major
// elements is assembled into a flat matrix bus held until the consumer takes it.
module mpu_matrix_loader #(
    parameter int MAX_N  = mpu_matrix_loader_pkg::MAX_N,
    parameter int ELEM_W = mpu_matrix_loader_pkg::ELEM_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [ELEM_W-1:0]               in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [MAX_N*MAX_N*ELEM_W-1:0]   out_matrix,
    output logic [7:0]                      out_size,
    output logic                            size_err
);

    import mpu_matrix_loader_pkg::*;

    localparam int CW = $clog2(MAX_N + 1);
    localparam int MW = MAX_N * MAX_N * ELEM_W;

    state_e        state_q, state_d;
    logic [MW-1:0] mat_q, mat_d;
    logic [7:0]    size_q, size_d;
    logic          out_valid_q, out_valid_d;
    logic          size_err_q, size_err_d;
    logic          cnt_clr, cnt_inc, cnt_last;
    logic [CW-1:0] row, col;
    logic          xfer, size_ok;

    assign in_ready   = (state_q != DONE);
    assign xfer       = in_valid && in_ready;
    assign size_ok    = (in_data != '0) && (in_data <= ELEM_W'(MAX_N));
    assign out_matrix = mat_q;
    assign out_size   = size_q;
    assign out_valid  = out_valid_q;
    assign size_err   = size_err_q;

    mpu_rc_counter #(.MAX_N(MAX_N), .CW(CW)) u_rc (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .size (size_q),
        .row  (row),
        .col  (col),
        .last (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        size_d      = size_q;
        mat_d       = mat_q;
        out_valid_d = out_valid_q;
        size_err_d  = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (size_ok) begin
                        // Clearing the whole array makes unused rows/cols read as zero
                        size_d  = 8'(in_data);
                        mat_d   = '0;
                        cnt_clr = 1'b1;
                        state_d = LOAD;
                    end else begin
                        size_err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    mat_d[elem_lsb(int'(row), int'(col), MAX_N, ELEM_W) +: ELEM_W] = in_data;
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mat_q       <= '0;
            size_q      <= '0;
            out_valid_q <= 1'b0;
            size_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mat_q       <= mat_d;
            size_q      <= size_d;
            out_valid_q <= out_valid_d;
            size_err_q  <= size_err_d;
        end
    end

endmodule
